seven_segment_mux: RTL and testbench

Parametrised, time-multiplexed driver for common-anode seven-segment displays with active-low anodes and segments. It supports a configurable digit count, PWM brightness, optional leading-zero blanking, and a double-buffered data load that updates the display only on frame boundaries, so the display never tears. It sits between user logic (switch readers, counters, debug registers) and the board's `anode`/`segment` pins, and is the standard display driver for new top levels.

---
 rtl/seven_segment_pkg.sv | 30 +++
 rtl/seven_segment_timebase.sv | 80 ++++++++
 rtl/seven_segment_mux.sv | 186 ++++++++++++++++++
 tb/tb_seven_segment_mux.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types, font table and helpers for the
// multiplexed seven-segment display driver.
package seven_segment_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Active-high a..g patterns, bit 0 = a
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Active-low segment word, dp in bit 7
  function automatic seg_t hex_to_seg(
    input logic [3:0] nibble,
    input logic       dp
  );
    return {~dp, ~FONT[nibble]};
  endfunction

  // Index width that stays legal for a single digit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_segment_timebase.sv
// Slot/digit counters, frame boundary strobe and
// PWM on-window for the display multiplexer.
module seven_segment_timebase
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_PERIOD = 100_000,
  parameter int BRIGHT_BITS  = 3,
  localparam int IW = idx_width(NUM_DIGITS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run_i,
  input  logic [BRIGHT_BITS-1:0] brightness_i,
  output logic [IW-1:0]          idx_o,
  output logic                   slot_on_o,
  output logic                   boundary_o,
  output logic                   frame_end_o
);

  localparam int TW =
    (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int STEP = DIGIT_PERIOD >> BRIGHT_BITS;
  localparam logic [TW-1:0] TICK_MAX =
    TW'(DIGIT_PERIOD - 1);
  localparam logic [IW-1:0] IDX_MAX =
    IW'(NUM_DIGITS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_end_q;
  logic          tick_last;
  logic          boundary;
  logic [31:0]   thresh;

  assign tick_last = run_i && (tick_q == TICK_MAX);
  assign boundary  = tick_last && (idx_q == IDX_MAX);

  // Advance tick every cycle, idx on tick wrap
  always_comb begin
    tick_d = tick_q;
    idx_d  = idx_q;
    if (run_i) begin
      if (tick_last) begin
        tick_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // Counter state and the post-wrap frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= '0;
      idx_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      frame_end_q <= boundary;
    end
  end

  // PWM window grows by STEP per brightness code
  always_comb begin
    thresh = (32'(brightness_i) + 32'd1) * 32'(STEP);
  end

  assign idx_o       = idx_q;
  assign slot_on_o   = 32'(tick_q) < thresh;
  assign boundary_o  = boundary;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode display driver with
// PWM dimming, zero blanking and frame-synced loads.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_PERIOD = 100_000,
  parameter int BRIGHT_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [NUM_DIGITS-1:0]   digit_point,
  input  logic                    load,
  input  logic                    blank_leading_zeros,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  logic                  run_q;
  logic [IW-1:0]         idx;
  logic                  slot_on;
  logic                  boundary;
  logic                  frame_end;

  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
  logic [NUM_DIGITS-1:0] pend_pt_q, pend_pt_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0] act_pt_q, act_pt_d;

  logic [NUM_DIGITS-1:0] blank;
  logic                  zrun;
  logic [3:0]            nib_sel;
  logic                  en_sel;
  logic                  pt_sel;
  logic                  bl_sel;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  lit;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  seg_t                  seg_q, seg_d;
  logic                  frame_done_q;

  // Reset release is retimed so counting starts cleanly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  seven_segment_timebase #(
    .NUM_DIGITS   (NUM_DIGITS),
    .DIGIT_PERIOD (DIGIT_PERIOD),
    .BRIGHT_BITS  (BRIGHT_BITS)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .run_i        (run_q),
    .brightness_i (brightness),
    .idx_o        (idx),
    .slot_on_o    (slot_on),
    .boundary_o   (boundary),
    .frame_end_o  (frame_end)
  );

  // Pending captures loads; active swaps only at boundary
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_en_d    = pend_en_q;
    pend_pt_d    = pend_pt_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    act_en_d     = act_en_q;
    act_pt_d     = act_pt_q;
    if (load) begin
      pend_data_d  = data_in;
      pend_en_d    = digit_enable;
      pend_pt_d    = digit_point;
      pend_valid_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        act_data_d   = data_in;
        act_en_d     = digit_enable;
        act_pt_d     = digit_point;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_data_d   = pend_data_q;
        act_en_d     = pend_en_q;
        act_pt_d     = pend_pt_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // Double-buffer storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_data_q  <= '0;
      pend_en_q    <= '0;
      pend_pt_q    <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_en_q     <= '0;
      act_pt_q     <= '0;
    end else begin
      pend_data_q  <= pend_data_d;
      pend_en_q    <= pend_en_d;
      pend_pt_q    <= pend_pt_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      act_en_q     <= act_en_d;
      act_pt_q     <= act_pt_d;
    end
  end

  // Blank digits above the highest non-zero or dotted one
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zrun = zrun
           & (act_data_q[4*k +: 4] == 4'h0)
           & ~act_pt_q[k];
      blank[k] = blank_leading_zeros & zrun & (k != 0);
    end
  end

  // Pick the fields of the digit currently scanned
  always_comb begin
    nib_sel = '0;
    en_sel  = 1'b0;
    pt_sel  = 1'b0;
    bl_sel  = 1'b0;
    onehot  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib_sel   = act_data_q[4*k +: 4];
        en_sel    = act_en_q[k];
        pt_sel    = act_pt_q[k];
        bl_sel    = blank[k];
        onehot[k] = 1'b1;
      end
    end
  end

  // Drive one anode low only while the digit is lit
  always_comb begin
    lit     = en_sel & ~bl_sel & slot_on;
    anode_d = '1;
    seg_d   = SEG_BLANK;
    if (lit) begin
      anode_d = ~onehot;
      seg_d   = hex_to_seg(nib_sel, pt_sel);
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode_q      <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_end;
    end
  end

  assign anode      = anode_q;
  assign segment    = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: 4-digit main
// instance plus an 8-digit instance for the sweep.
module tb_seven_segment_mux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [3:0]  digit_enable;
  logic [3:0]  digit_point;
  logic        load;
  logic        blz;
  logic [1:0]  brightness;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic        frame_done;

  logic        rst2_n;
  logic [31:0] data2;
  logic [7:0]  en2;
  logic [7:0]  pt2;
  logic        load2;
  logic        blz2;
  logic [2:0]  bri2;
  logic [7:0]  seg2;
  logic [7:0]  an2;
  logic        fd2;

  int vectors = 0;
  int miscompares = 0;
  int cnt [4];
  logic [3:0] an [4];
  logic [7:0] sg [4];
  int dark_lit;

  always #5 clk = ~clk;

  seven_segment_mux #(
    .NUM_DIGITS   (4),
    .DIGIT_PERIOD (16),
    .BRIGHT_BITS  (2)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .data_in             (data_in),
    .digit_enable        (digit_enable),
    .digit_point         (digit_point),
    .load                (load),
    .blank_leading_zeros (blz),
    .brightness          (brightness),
    .segment             (segment),
    .anode               (anode),
    .frame_done          (frame_done)
  );

  seven_segment_mux #(
    .NUM_DIGITS   (8),
    .DIGIT_PERIOD (32),
    .BRIGHT_BITS  (3)
  ) dut2 (
    .clk                 (clk),
    .reset_n             (rst2_n),
    .data_in             (data2),
    .digit_enable        (en2),
    .digit_point         (pt2),
    .load                (load2),
    .blank_leading_zeros (blz2),
    .brightness          (bri2),
    .segment             (seg2),
    .anode               (an2),
    .frame_done          (fd2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run to the next frame_done, counting lit cycles
  task automatic wait_frame();
    int n = 0;
    dark_lit = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      if (anode !== 4'hF) dark_lit++;
      step();
      n++;
    end
    chk("frame_timeout", 32'(frame_done), 1);
  endtask

  // Scan one frame from a frame_done sample; optional loads
  task automatic scan_frame(
    input int          la,
    input logic [15:0] da,
    input int          lb,
    input logic [15:0] db
  );
    int s;
    for (int i = 0; i < 64; i++) begin
      s = i / 16;
      if (i == 0) chk("frame_align", 32'(frame_done), 1);
      if (i % 16 == 0) begin
        cnt[s] = 0;
        an[s]  = 4'hF;
        sg[s]  = 8'hFF;
      end
      if (anode !== 4'hF) begin
        cnt[s]++;
        an[s] = anode;
        sg[s] = segment;
      end
      if (i == la) begin
        data_in = da;
        load    = 1'b1;
      end
      if (i == lb) begin
        data_in = db;
        load    = 1'b1;
      end
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    int n;
    int bad;
    int early;
    logic [7:0] exp_an;

    reset_n = 1'b0;
    rst2_n  = 1'b0;
    data_in = '0;
    digit_enable = '0;
    digit_point  = '0;
    load = 1'b0;
    blz  = 1'b0;
    brightness = 2'd3;
    data2 = '0;
    en2   = '0;
    pt2   = '0;
    load2 = 1'b0;
    blz2  = 1'b0;
    bri2  = 3'd7;
    repeat (3) step();

    // Reset state
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(segment), 32'hFF);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_pend", 32'(dut.pend_valid_q), 0);

    // 1. Basic display
    reset_n = 1'b1;
    rst2_n  = 1'b1;
    data_in = 16'h1234;
    digit_enable = 4'hF;
    data2 = 32'h7654_3210;
    en2   = 8'hFF;
    load  = 1'b1;
    load2 = 1'b1;
    step();
    load  = 1'b0;
    load2 = 1'b0;
    chk("pend_set", 32'(dut.pend_valid_q), 1);
    wait_frame();
    chk("dark_before", 32'(dark_lit), 0);
    scan_frame(-1, '0, -1, '0);
    chk("b_cnt0", 32'(cnt[0]), 16);
    chk("b_an0", 32'(an[0]), 32'hE);
    chk("b_sg0", 32'(sg[0]), 32'h99);
    chk("b_cnt1", 32'(cnt[1]), 16);
    chk("b_an1", 32'(an[1]), 32'hD);
    chk("b_sg1", 32'(sg[1]), 32'hB0);
    chk("b_sg3", 32'(sg[3]), 32'hF9);
    chk("pend_clr", 32'(dut.pend_valid_q), 0);

    // 2. Brightness
    brightness = 2'd1;
    scan_frame(-1, '0, -1, '0);
    chk("br1_cnt0", 32'(cnt[0]), 8);
    chk("br1_cnt3", 32'(cnt[3]), 8);
    chk("br1_an3", 32'(an[3]), 32'h7);
    brightness = 2'd0;
    scan_frame(-1, '0, -1, '0);
    chk("br0_cnt1", 32'(cnt[1]), 4);
    chk("br0_an1", 32'(an[1]), 32'hD);
    brightness = 2'd3;

    // 3. Leading-zero blanking
    blz = 1'b1;
    scan_frame(5, 16'h0050, -1, '0);
    scan_frame(-1, '0, -1, '0);
    chk("lz_sg0", 32'(sg[0]), 32'hC0);
    chk("lz_sg1", 32'(sg[1]), 32'h92);
    chk("lz_cnt2", 32'(cnt[2]), 0);
    chk("lz_cnt3", 32'(cnt[3]), 0);
    digit_point = 4'b0100;
    scan_frame(5, 16'h0050, -1, '0);
    scan_frame(-1, '0, -1, '0);
    chk("lzp_cnt2", 32'(cnt[2]), 16);
    chk("lzp_sg2", 32'(sg[2]), 32'h40);
    chk("lzp_an2", 32'(an[2]), 32'hB);
    chk("lzp_cnt3", 32'(cnt[3]), 0);
    blz = 1'b0;
    scan_frame(-1, '0, -1, '0);
    chk("nolz_cnt3", 32'(cnt[3]), 16);
    chk("nolz_sg3", 32'(sg[3]), 32'hC0);

    // 4. Buffering
    digit_point = 4'b0000;
    scan_frame(10, 16'hAAAA, -1, '0);
    chk("buf_old0", 32'(sg[0]), 32'hC0);
    chk("buf_old2", 32'(sg[2]), 32'h40);
    scan_frame(-1, '0, -1, '0);
    chk("buf_new0", 32'(sg[0]), 32'h88);
    chk("buf_new2", 32'(sg[2]), 32'h88);
    scan_frame(3, 16'h1111, 20, 16'h2222);
    chk("two_old1", 32'(sg[1]), 32'h88);
    scan_frame(-1, '0, -1, '0);
    chk("two_new0", 32'(sg[0]), 32'hA4);
    chk("two_new3", 32'(sg[3]), 32'hA4);
    scan_frame(62, 16'h3333, -1, '0);
    chk("bnd_old3", 32'(sg[3]), 32'hA4);
    chk("bnd_pend", 32'(dut.pend_valid_q), 0);
    scan_frame(-1, '0, -1, '0);
    chk("bnd_new0", 32'(sg[0]), 32'hB0);
    chk("bnd_cnt0", 32'(cnt[0]), 16);

    // 5. Reset mid-operation
    step();
    data_in = 16'h4444;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    chk("pre_rst_lit", 32'(anode), 32'hE);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(anode), 32'hF);
    chk("mid_rst_seg", 32'(segment), 32'hFF);
    chk("mid_rst_pend", 32'(dut.pend_valid_q), 0);
    repeat (2) step();
    #3;
    reset_n = 1'b1;
    step();
    wait_frame();
    chk("post_rst_dark", 32'(dark_lit), 0);
    scan_frame(-1, '0, -1, '0);
    chk("post_cnt0", 32'(cnt[0]), 0);
    chk("post_cnt3", 32'(cnt[3]), 0);
    scan_frame(0, 16'h5555, -1, '0);
    scan_frame(-1, '0, -1, '0);
    chk("reload_cnt2", 32'(cnt[2]), 16);
    chk("reload_sg2", 32'(sg[2]), 32'h92);

    // 6. Eight-digit sweep
    n = 0;
    while (fd2 !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    chk("fd2_timeout", 32'(fd2), 1);
    bad = 0;
    early = 0;
    for (int c = 0; c < 256; c++) begin
      if ($countones(~an2) != 1) bad++;
      if (c % 32 == 0) begin
        exp_an = ~(8'd1 << (c / 32));
        chk("walk", 32'(an2), 32'(exp_an));
      end
      if (c > 0 && fd2) early++;
      if (c == 0) chk("sw_sg0", 32'(seg2), 32'hC0);
      if (c == 224) chk("sw_sg7", 32'(seg2), 32'hF8);
      step();
    end
    chk("fd2_period", 32'(fd2), 1);
    chk("onehot", 32'(bad), 0);
    chk("fd2_early", 32'(early), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
